// File: rtl/vreg_pkg.sv
// Shared types and helpers for the vector register file.
package vreg_pkg;

   typedef enum logic {CLEAR, IDLE} state_t;

   localparam int LANE_W = 8;
   localparam int AW     = 5;

   // One byte lane of a masked write; the storage write and the bypass both use it.
   function automatic logic [LANE_W-1:0] lane_merge(input logic [LANE_W-1:0] old_v,
                                                    input logic [LANE_W-1:0] new_v,
                                                    input logic              mask);
      return mask ? new_v : old_v;
   endfunction

endpackage

// File: rtl/vreg_file_if.sv
// Decode/writeback bundle of the vector register file.
interface vreg_file_if import vreg_pkg::*; #(
   parameter int WIDTH = 256,
   parameter int NREAD = 2
);
   localparam int NLANE = WIDTH / LANE_W;

   logic [NREAD-1:0][AW-1:0]    RA;
   logic [NREAD-1:0][WIDTH-1:0] RD;
   logic [AW-1:0]               A3;
   logic [WIDTH-1:0]            WB;
   logic                        WE;
   logic [NLANE-1:0]            WMASK;
   logic                        CLR;
   logic                        READY;

   modport master (output RA, A3, WB, WE, WMASK, CLR, input RD, READY);
   modport slave  (input RA, A3, WB, WE, WMASK, CLR, output RD, READY);
endinterface

// File: rtl/vreg_rdport.sv
// One registered read port: range check, write bypass and lane merge.
module vreg_rdport import vreg_pkg::*; #(
   parameter int WIDTH = 256,
   parameter int DEPTH = 4
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        zero,
   input  logic [DEPTH-1:0][WIDTH-1:0] mem,
   input  logic [AW-1:0]               ra,
   input  logic                        we,
   input  logic [AW-1:0]               a3,
   input  logic [WIDTH-1:0]            wb,
   input  logic [WIDTH/LANE_W-1:0]     wmask,
   output logic [WIDTH-1:0]            rd
);
   localparam int            NLANE   = WIDTH / LANE_W;
   localparam int            IW      = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

   logic             in_range;
   logic             hit;
   logic [WIDTH-1:0] old_w;
   logic [WIDTH-1:0] rd_nx;

   // we is already qualified by the top, so a hit implies a valid address.
   always_comb begin
      in_range = ({1'b0, ra} < DEPTH_C);
      hit      = we && (a3 == ra);
      old_w    = in_range ? mem[ra[IW-1:0]] : '0;
      rd_nx    = old_w;
      if (hit) begin
         for (int i = 0; i < NLANE; i++) begin
            rd_nx[i*LANE_W +: LANE_W] = lane_merge(old_w[i*LANE_W +: LANE_W],
                                                   wb[i*LANE_W +: LANE_W], wmask[i]);
         end
      end
      if (zero || !in_range) rd_nx = '0;
   end

   always_ff @(posedge CLK) begin
      if (!RST) rd <= '0;
      else      rd <= rd_nx;
   end
endmodule

// File: rtl/vreg_file.sv
// Vector register file with byte-masked writes, read bypass and a sequenced clear sweep.
//  state | meaning
//  CLEAR | writing reset image into entry[idx], one entry per cycle; RD forced 0
//  IDLE  | normal reads/writes, READY high
module vreg_file import vreg_pkg::*; #(
   parameter int               WIDTH = 256,
   parameter int               DEPTH = 4,
   parameter int               NREAD = 2,
   parameter logic [WIDTH-1:0] INIT0 = 256'h4142434445464748494a4b4c4d4e4f50
) (
   input logic        CLK,
   input logic        RST,
   vreg_file_if.slave bus
);
   localparam int            NLANE   = WIDTH / LANE_W;
   localparam int            IW      = $clog2(DEPTH);
   localparam logic [IW-1:0] LAST    = IW'(DEPTH - 1);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

   state_t                      state, state_nx;
   logic [IW-1:0]               idx, idx_nx;
   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic                        sweep_we;
   logic                        wr_en;
   logic                        rd_zero;
   logic [IW-1:0]               a3_i;
   logic [WIDTH-1:0]            wr_word;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state <= CLEAR;
         idx   <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
      end
   end

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      sweep_we = 1'b0;
      case (state)
         CLEAR: begin
            sweep_we = 1'b1;
            if (idx == LAST) begin
               state_nx = IDLE;
               idx_nx   = '0;
            end else begin
               idx_nx = idx + 1'b1;
            end
         end
         IDLE: begin
            if (bus.CLR) begin
               state_nx = CLEAR;
               idx_nx   = '0;
            end
         end
         default: state_nx = CLEAR;
      endcase
   end

   // A CLR in IDLE drops the same-cycle write and blanks the same-cycle reads.
   assign wr_en   = (state == IDLE) && !bus.CLR && bus.WE && ({1'b0, bus.A3} < DEPTH_C);
   assign rd_zero = (state == CLEAR) || bus.CLR;
   assign a3_i    = bus.A3[IW-1:0];

   always_comb begin
      wr_word = mem[a3_i];
      for (int i = 0; i < NLANE; i++) begin
         wr_word[i*LANE_W +: LANE_W] = lane_merge(mem[a3_i][i*LANE_W +: LANE_W],
                                                  bus.WB[i*LANE_W +: LANE_W], bus.WMASK[i]);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         if (sweep_we)   mem[idx]  <= (idx == '0) ? INIT0 : '0;
         else if (wr_en) mem[a3_i] <= wr_word;
      end
   end

   assign bus.READY = (state == IDLE);

   for (genvar p = 0; p < NREAD; p++) begin : g_rd
      vreg_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rd (
         .CLK   (CLK),
         .RST   (RST),
         .zero  (rd_zero),
         .mem   (mem),
         .ra    (bus.RA[p]),
         .we    (wr_en),
         .a3    (bus.A3),
         .wb    (bus.WB),
         .wmask (bus.WMASK),
         .rd    (bus.RD[p])
      );
   end
endmodule

// File: tb/tb_vreg_file.sv
// Directed bench for vreg_file: default instance (DEPTH 4) plus a DEPTH 3 instance.
module tb_vreg_file;
   import vreg_pkg::*;

   localparam logic [255:0] INIT0 = 256'h4142434445464748494a4b4c4d4e4f50;
   localparam logic [255:0] ONES  = {256{1'b1}};
   localparam logic [255:0] F55   = {32{8'h55}};
   localparam logic [255:0] HALF  = {{16{8'h00}}, {16{8'hFF}}};
   localparam logic [255:0] PART  = {{16{8'h00}}, {15{8'hFF}}, 8'h00};

   logic clk;
   logic rst0, rst1;
   int   errors = 0;
   int   checks = 0;

   vreg_file_if #(.WIDTH(256), .NREAD(2)) bus0 ();
   vreg_file_if #(.WIDTH(256), .NREAD(2)) bus1 ();

   vreg_file u0 (.CLK(clk), .RST(rst0), .bus(bus0));
   vreg_file #(.DEPTH(3)) u1 (.CLK(clk), .RST(rst1), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      bus0.RA = '0; bus0.A3 = '0; bus0.WB = '0; bus0.WE = 1'b0; bus0.WMASK = '0; bus0.CLR = 1'b0;
      bus1.RA = '0; bus1.A3 = '0; bus1.WB = '0; bus1.WE = 1'b0; bus1.WMASK = '0; bus1.CLR = 1'b0;
      rst0 = 1'b0;
      rst1 = 1'b0;
      tick();
      tick();
      chk("rst_ready0", 256'(bus0.READY), 256'd0);
      chk("rst_rd0", bus0.RD[0], '0);
      chk("rst_ready1", 256'(bus1.READY), 256'd0);

      // reset release: sweep of DEPTH edges
      rst0 = 1'b1;
      rst1 = 1'b1;
      bus0.RA[0] = 5'd0;
      bus0.RA[1] = 5'd1;
      tick();
      chk("sweep_e1_ready", 256'(bus0.READY), 256'd0);
      chk("sweep_e1_rd", bus0.RD[0], '0);
      tick();
      chk("sweep_e2_ready", 256'(bus0.READY), 256'd0);
      tick();
      chk("sweep_e3_ready", 256'(bus0.READY), 256'd0);
      chk("sweep_d3_ready", 256'(bus1.READY), 256'd1);
      tick();
      chk("sweep_e4_ready", 256'(bus0.READY), 256'd1);

      tick();
      chk("rd_e0", bus0.RD[0], INIT0);
      chk("rd_e1", bus0.RD[1], '0);
      bus0.RA[0] = 5'd2;
      bus0.RA[1] = 5'd3;
      tick();
      chk("rd_e2", bus0.RD[0], '0);
      chk("rd_e3", bus0.RD[1], '0);

      // masked write of lower 16 bytes
      bus0.WE = 1'b1; bus0.A3 = 5'd2; bus0.WB = ONES; bus0.WMASK = 32'h0000_FFFF;
      bus0.RA[0] = 5'd0;
      tick();
      chk("wr_other_port", bus0.RD[0], INIT0);
      bus0.WE = 1'b0;
      bus0.RA[0] = 5'd2;
      tick();
      chk("mask_half", bus0.RD[0], HALF);

      // full-mask bypass on both ports
      bus0.WE = 1'b1; bus0.A3 = 5'd1; bus0.WB = F55; bus0.WMASK = '1;
      bus0.RA[0] = 5'd1;
      bus0.RA[1] = 5'd1;
      tick();
      chk("byp_p0", bus0.RD[0], F55);
      chk("byp_p1", bus0.RD[1], F55);

      // partial bypass merges with stored value
      bus0.A3 = 5'd2; bus0.WB = '0; bus0.WMASK = 32'h0000_0001;
      bus0.RA[0] = 5'd2;
      tick();
      chk("byp_part", bus0.RD[0], PART);
      chk("byp_nohit", bus0.RD[1], F55);
      bus0.WE = 1'b0;
      tick();
      chk("stored_part", bus0.RD[0], PART);

      bus0.RA[0] = 5'd31;
      bus0.WE = 1'b1; bus0.A3 = 5'd31; bus0.WB = ONES; bus0.WMASK = '1;
      tick();
      chk("oor_rd", bus0.RD[0], '0);

      // CLR with a same-cycle write to entry 0
      bus0.A3 = 5'd0; bus0.CLR = 1'b1;
      bus0.RA[0] = 5'd0;
      bus0.RA[1] = 5'd2;
      tick();
      chk("clr_rd0", bus0.RD[0], '0);
      chk("clr_rd1", bus0.RD[1], '0);
      chk("clr_ready", 256'(bus0.READY), 256'd0);
      bus0.WE = 1'b0; bus0.CLR = 1'b0;
      tick();
      chk("clr_a_ready", 256'(bus0.READY), 256'd0);
      bus0.CLR = 1'b1;
      tick();
      chk("clr_b_ready", 256'(bus0.READY), 256'd0);
      bus0.CLR = 1'b0;
      tick();
      chk("clr_c_ready", 256'(bus0.READY), 256'd0);
      tick();
      chk("clr_d_ready", 256'(bus0.READY), 256'd1);
      bus0.RA[0] = 5'd0;
      bus0.RA[1] = 5'd1;
      tick();
      chk("clr_e0", bus0.RD[0], INIT0);
      chk("clr_e1", bus0.RD[1], '0);
      bus0.RA[0] = 5'd2;
      tick();
      chk("clr_e2", bus0.RD[0], '0);

      // reset at sweep idx 2 restarts the sweep
      bus0.CLR = 1'b1;
      tick();
      bus0.CLR = 1'b0;
      tick();
      tick();
      rst0 = 1'b0;
      tick();
      chk("mid_rst_ready", 256'(bus0.READY), 256'd0);
      rst0 = 1'b1;
      tick();
      chk("mid_e1_ready", 256'(bus0.READY), 256'd0);
      tick();
      chk("mid_e2_ready", 256'(bus0.READY), 256'd0);
      tick();
      chk("mid_e3_ready", 256'(bus0.READY), 256'd0);
      tick();
      chk("mid_e4_ready", 256'(bus0.READY), 256'd1);

      // DEPTH 3 instance: out-of-range addresses
      bus1.WE = 1'b1; bus1.A3 = 5'd2; bus1.WB = ONES; bus1.WMASK = '1;
      tick();
      bus1.A3 = 5'd5; bus1.WB = F55;
      bus1.RA[0] = 5'd5;
      bus1.RA[1] = 5'd2;
      tick();
      chk("d3_byp_oor", bus1.RD[0], '0);
      chk("d3_e2", bus1.RD[1], ONES);
      bus1.A3 = 5'd3;
      bus1.RA[0] = 5'd3;
      bus1.RA[1] = 5'd1;
      tick();
      chk("d3_ra3", bus1.RD[0], '0);
      chk("d3_e1_a", bus1.RD[1], '0);
      bus1.WE = 1'b0;
      bus1.RA[0] = 5'd0;
      bus1.RA[1] = 5'd1;
      tick();
      chk("d3_e0", bus1.RD[0], INIT0);
      chk("d3_e1_b", bus1.RD[1], '0);
      bus1.RA[0] = 5'd2;
      tick();
      chk("d3_e2_b", bus1.RD[0], ONES);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
